// File: rtl/alu_acc_pkg.sv
// alu_acc_pkg: shared definitions for the cascadable ALU/accumulator.
// Holds the run-time mode encodings and the saturation-bound helper.
package alu_acc_pkg;

    typedef enum logic [1:0] {
        MODE_ADD_ACC  = 2'd0,
        MODE_CASC_ACC = 2'd1,
        MODE_CASC     = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    // Bit idx of the clamp value for a w-bit result.
    // hi=1 selects the upper bound, hi=0 the lower bound.
    // Signed: 0111..1 / 1000..0.  Unsigned: 1111..1 / 0000..0.
    function automatic logic sat_bound(
        input int   w,
        input logic sgn,
        input logic hi,
        input int   idx
    );
        logic r;
        if (hi) begin
            r = (idx < w - 1) || ((idx == w - 1) && !sgn);
        end else begin
            r = (idx == w - 1) && sgn;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_acc_core.sv
// alu_acc_core: combinational datapath of the ALU/accumulator.
// Inputs: a, b, casi, acc plus sign/sub/mode/accload controls.
// Outputs: dout (wrapped or clamped), caso (pre-saturation sum), overflow.
module alu_acc_core
    import alu_acc_pkg::*;
#(
    parameter int WIDTH    = 54,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH:0]   i_casi,
    input  logic [WIDTH-1:0] i_acc,
    input  logic             i_asign,
    input  logic             i_bsign,
    input  logic             i_bsub,
    input  logic             i_csub,
    input  logic [1:0]       i_mode,
    input  logic             i_accload,
    output logic [WIDTH-1:0] o_dout,
    output logic [WIDTH:0]   o_caso,
    output logic             o_overflow
);

    localparam int SW = WIDTH + 2;

    logic             w_signed;
    logic             w_rsvd;
    logic             w_hi;
    logic             w_ovf;
    logic [SW-1:0]    w_ea;
    logic [SW-1:0]    w_eb;
    logic [SW-1:0]    w_ecasi;
    logic [SW-1:0]    w_eacc;
    logic [SW-1:0]    w_acc_sel;
    logic [SW-1:0]    w_op1;
    logic [SW-1:0]    w_op3;
    logic [SW-1:0]    w_opb;
    logic [SW-1:0]    w_opc;
    logic [SW-1:0]    w_sum;
    logic [WIDTH-1:0] w_bound;

    assign w_signed = i_asign | i_bsign;

    assign w_ea    = {{2{i_asign & i_a[WIDTH-1]}}, i_a};
    assign w_eb    = {{2{i_bsign & i_b[WIDTH-1]}}, i_b};
    assign w_ecasi = {i_casi[WIDTH], i_casi};

    // acc holds a previous result, so it follows the result signedness.
    assign w_eacc    = {{2{w_signed & i_acc[WIDTH-1]}}, i_acc};
    assign w_acc_sel = i_accload ? w_eacc : '0;

    always_comb begin
        w_op1  = '0;
        w_op3  = '0;
        w_rsvd = 1'b0;
        unique case (i_mode)
            MODE_ADD_ACC: begin
                w_op1 = w_ea;
                w_op3 = w_acc_sel;
            end
            MODE_CASC_ACC: begin
                w_op1 = w_acc_sel;
                w_op3 = w_ecasi;
            end
            MODE_CASC: begin
                w_op1 = w_ea;
                w_op3 = w_ecasi;
            end
            default: begin
                w_rsvd = 1'b1;
            end
        endcase
    end

    assign w_opb = w_rsvd ? '0 : (i_bsub ? -w_eb : w_eb);
    assign w_opc = i_csub ? -w_op3 : w_op3;
    assign w_sum = w_op1 + w_opb + w_opc;

    // Signed fits when the top three bits agree; unsigned when top two are 0.
    assign w_ovf = w_signed
        ? !((&w_sum[SW-1:WIDTH-1]) || !(|w_sum[SW-1:WIDTH-1]))
        : (|w_sum[SW-1:WIDTH]);

    assign w_hi = ~w_sum[SW-1];

    always_comb begin
        w_bound = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bound[i] = sat_bound(WIDTH, w_signed, w_hi, i);
        end
    end

    assign o_dout     = ((SATURATE != 0) && w_ovf) ? w_bound : w_sum[WIDTH-1:0];
    assign o_caso     = w_sum[WIDTH:0];
    assign o_overflow = w_ovf;

endmodule

// File: rtl/alu_acc_chain.sv
// alu_acc_chain: pipelined cascadable ALU/accumulator top level.
// Ports: clk, reset (sync, active-low), ce, in_valid, a, b, casi, controls;
// outputs out_valid, dout, caso, overflow. Optional input/output registers.
module alu_acc_chain
    import alu_acc_pkg::*;
#(
    parameter int WIDTH    = 54,
    parameter int IN_REG   = 1,
    parameter int OUT_REG  = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   casi,
    input  logic             asign,
    input  logic             bsign,
    input  logic             b_sub,
    input  logic             c_sub,
    input  logic [1:0]       mode,
    input  logic             accload,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH:0]   caso,
    output logic             overflow
);

    // Compute-stage view of the sample
    logic             w_v;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_casi;
    logic             w_asign;
    logic             w_bsign;
    logic             w_bsub;
    logic             w_csub;
    logic [1:0]       w_mode;
    logic             w_accload;

    logic [WIDTH-1:0] w_dout;
    logic [WIDTH:0]   w_caso;
    logic             w_ovf;

    logic [WIDTH-1:0] r_acc;

    if (IN_REG != 0) begin : g_in
        logic             r_v;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH:0]   r_casi;
        logic             r_asign;
        logic             r_bsign;
        logic             r_bsub;
        logic             r_csub;
        logic [1:0]       r_mode;
        logic             r_accload;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_v       <= 1'b0;
                r_a       <= '0;
                r_b       <= '0;
                r_casi    <= '0;
                r_asign   <= 1'b0;
                r_bsign   <= 1'b0;
                r_bsub    <= 1'b0;
                r_csub    <= 1'b0;
                r_mode    <= 2'd0;
                r_accload <= 1'b0;
            end else if (ce) begin
                r_v       <= in_valid;
                r_a       <= a;
                r_b       <= b;
                r_casi    <= casi;
                r_asign   <= asign;
                r_bsign   <= bsign;
                r_bsub    <= b_sub;
                r_csub    <= c_sub;
                r_mode    <= mode;
                r_accload <= accload;
            end
        end

        assign w_v       = r_v;
        assign w_a       = r_a;
        assign w_b       = r_b;
        assign w_casi    = r_casi;
        assign w_asign   = r_asign;
        assign w_bsign   = r_bsign;
        assign w_bsub    = r_bsub;
        assign w_csub    = r_csub;
        assign w_mode    = r_mode;
        assign w_accload = r_accload;
    end else begin : g_no_in
        assign w_v       = in_valid;
        assign w_a       = a;
        assign w_b       = b;
        assign w_casi    = casi;
        assign w_asign   = asign;
        assign w_bsign   = bsign;
        assign w_bsub    = b_sub;
        assign w_csub    = c_sub;
        assign w_mode    = mode;
        assign w_accload = accload;
    end

    alu_acc_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .i_a        (w_a),
        .i_b        (w_b),
        .i_casi     (w_casi),
        .i_acc      (r_acc),
        .i_asign    (w_asign),
        .i_bsign    (w_bsign),
        .i_bsub     (w_bsub),
        .i_csub     (w_csub),
        .i_mode     (w_mode),
        .i_accload  (w_accload),
        .o_dout     (w_dout),
        .o_caso     (w_caso),
        .o_overflow (w_ovf)
    );

    // Single-cycle feedback: acc takes the final dout of each valid sample.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (ce && w_v && (w_mode != MODE_RSVD)) begin
            r_acc <= w_dout;
        end
    end

    if (OUT_REG != 0) begin : g_out
        logic             r_out_valid;
        logic [WIDTH-1:0] r_dout;
        logic [WIDTH:0]   r_caso;
        logic             r_ovf;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_out_valid <= 1'b0;
                r_dout      <= '0;
                r_caso      <= '0;
                r_ovf       <= 1'b0;
            end else if (ce) begin
                r_out_valid <= w_v;
                if (w_v) begin
                    r_dout <= w_dout;
                    r_caso <= w_caso;
                    r_ovf  <= w_ovf;
                end
            end
        end

        assign out_valid = r_out_valid;
        assign dout      = r_dout;
        assign caso      = r_caso;
        assign overflow  = r_ovf;
    end else begin : g_no_out
        assign out_valid = w_v;
        assign dout      = w_dout;
        assign caso      = w_caso;
        assign overflow  = w_ovf;
    end

endmodule

// File: tb/tb_alu_acc_chain.sv
// tb_alu_acc_chain: self-checking bench for alu_acc_chain.
// Directed scenarios plus randomized traffic against an arithmetic model.
module tb_alu_acc_chain;

    localparam int W = 54;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic         reset;
    logic         ce;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   casi;
    logic         asign;
    logic         bsign;
    logic         b_sub;
    logic         c_sub;
    logic [1:0]   mode;
    logic         accload;

    logic         ov, s_ov, c_ov;
    logic [W-1:0] dout, s_dout, c_dout;
    logic [W:0]   caso, s_caso, c_caso;
    logic         ovf, s_ovf, c_ovf;

    logic [W-1:0] c_a = '0;
    logic [W-1:0] c_b = W'(2);
    logic         c_zero = 1'b0;
    logic [1:0]   c_mode = 2'd1;

    alu_acc_chain #(.WIDTH(W), .IN_REG(1), .OUT_REG(1), .SATURATE(0)) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .casi(casi), .asign(asign), .bsign(bsign),
        .b_sub(b_sub), .c_sub(c_sub), .mode(mode), .accload(accload),
        .out_valid(ov), .dout(dout), .caso(caso), .overflow(ovf)
    );

    alu_acc_chain #(.WIDTH(W), .IN_REG(1), .OUT_REG(1), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .a(a), .b(b), .casi(casi), .asign(asign), .bsign(bsign),
        .b_sub(b_sub), .c_sub(c_sub), .mode(mode), .accload(accload),
        .out_valid(s_ov), .dout(s_dout), .caso(s_caso), .overflow(s_ovf)
    );

    alu_acc_chain #(.WIDTH(W), .IN_REG(0), .OUT_REG(1), .SATURATE(0)) dut_c (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(ov),
        .a(c_a), .b(c_b), .casi(caso), .asign(c_zero), .bsign(c_zero),
        .b_sub(c_zero), .c_sub(c_zero), .mode(c_mode), .accload(c_zero),
        .out_valid(c_ov), .dout(c_dout), .caso(c_caso), .overflow(c_ovf)
    );

    typedef struct {
        logic [W-1:0] a, b;
        logic [W:0]   casi;
        logic         asg, bsg, bs, cs, al;
        logic [1:0]   md;
    } smp_t;

    typedef struct {
        logic [W-1:0] d;
        logic [W:0]   c;
        logic         o;
    } res_t;

    localparam longint TW  = longint'(1) << W;
    localparam longint TW1 = TW >> 1;
    localparam longint TW2 = TW << 1;
    localparam longint TW4 = TW << 2;

    // Integer-arithmetic reference: extend, add, wrap to W+2 bits, range-check.
    function automatic res_t model(input smp_t s, input bit sat,
                                   inout logic [W-1:0] acc);
        res_t   r;
        longint ea, eb, ec, eacc, acc_t, sum;
        bit     sg;
        sg = s.asg | s.bsg;
        ea = longint'(s.a);
        if (s.asg && s.a[W-1]) ea -= TW;
        eb = longint'(s.b);
        if (s.bsg && s.b[W-1]) eb -= TW;
        ec = longint'(s.casi);
        if (s.casi[W]) ec -= TW2;
        eacc = longint'(acc);
        if (sg && acc[W-1]) eacc -= TW;
        acc_t = s.al ? eacc : 0;
        if (s.bs) eb = -eb;
        case (s.md)
            2'd0: sum = ea + eb + (s.cs ? -acc_t : acc_t);
            2'd1: sum = acc_t + eb + (s.cs ? -ec : ec);
            2'd2: sum = ea + eb + (s.cs ? -ec : ec);
            default: sum = 0;
        endcase
        sum = sum & (TW4 - 1);
        if (sum >= TW2) sum -= TW4;
        r.o = sg ? (sum < -TW1 || sum >= TW1) : (sum < 0 || sum >= TW);
        if (sat && r.o) begin
            if (sg) r.d = (sum < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else    r.d = (sum < 0) ? '0 : '1;
        end else begin
            r.d = sum[W-1:0];
        end
        r.c = sum[W:0];
        if (s.md != 2'd3) acc = r.d;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ce = 1'b1; in_valid = 1'b0;
        a = '0; b = '0; casi = '0;
        asign = 1'b0; bsign = 1'b0; b_sub = 1'b0; c_sub = 1'b0;
        mode = 2'd0; accload = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        a = W'(123); b = W'(45); in_valid = 1'b1;
        ce = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ov); end
        n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
        n_chk++; if (caso !== '0) begin n_fail++; $display("FAIL reset_caso got %h want 0", caso); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
        reset = 1'b1; ce = 1'b1;
        a = W'(5); b = '0; accload = 1'b1; mode = 2'd0;
        tick();
        in_valid = 1'b0;
        tick();
        n_chk++; if (dout !== W'(5)) begin n_fail++; $display("FAIL reset_acc got %h want 5", dout); end
    endtask

    task automatic test_basic();
        do_reset();
        a = W'(64'hde1ec7ab1e); b = W'(64'hcad); b_sub = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_early got %b want 0", ov); end
        tick();
        n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", ov); end
        n_chk++; if (dout !== W'(64'hde1ec79e71)) begin n_fail++; $display("FAIL basic_dout got %h want de1ec79e71", dout); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        a = W'(1); accload = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 4);
            tick();
            if (i >= 1 && i <= 4) begin
                n_chk++;
                if (ov !== 1'b1 || dout !== W'(i)) begin
                    n_fail++; $display("FAIL b2b_%0d got v=%b d=%h want v=1 d=%h", i, ov, dout, W'(i));
                end
            end else if (i >= 5) begin
                n_chk++;
                if (ov !== 1'b0 || dout !== W'(4)) begin
                    n_fail++; $display("FAIL b2b_idle got v=%b d=%h want v=0 d=4", ov, dout);
                end
            end
        end
    endtask

    task automatic test_cascade();
        do_reset();
        mode = 2'd2; a = W'(64'h100000000); b = W'(64'hf000); casi = (W+1)'(64'h1111);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_chk++; if (dout !== W'(64'h100010111)) begin n_fail++; $display("FAIL casc_dout got %h want 100010111", dout); end
        n_chk++; if (caso !== (W+1)'(64'h100010111)) begin n_fail++; $display("FAIL casc_caso got %h want 100010111", caso); end
        tick();
        n_chk++; if (c_ov !== 1'b1) begin n_fail++; $display("FAIL chain_valid got %b want 1", c_ov); end
        n_chk++; if (c_dout !== W'(64'h100010113)) begin n_fail++; $display("FAIL chain_dout got %h want 100010113", c_dout); end
        n_chk++; if (c_caso !== (W+1)'(64'h100010113) || c_ovf !== 1'b0) begin
            n_fail++; $display("FAIL chain_caso got %h/%b want 100010113/0", c_caso, c_ovf);
        end
    endtask

    task automatic test_saturate();
        logic [W:0] exp_c;
        exp_c = {1'b1, {W{1'b0}}};
        do_reset();
        mode = 2'd2; a = '1; b = W'(1); casi = '0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_chk++; if (s_dout !== {W{1'b1}} || s_ovf !== 1'b1) begin
            n_fail++; $display("FAIL sat_dout got %h/%b want max/1", s_dout, s_ovf);
        end
        n_chk++; if (s_caso !== exp_c) begin n_fail++; $display("FAIL sat_caso got %h want %h", s_caso, exp_c); end
        n_chk++; if (dout !== '0 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL wrap_dout got %h/%b want 0/1", dout, ovf);
        end
    endtask

    task automatic test_ce_freeze();
        do_reset();
        a = W'(1); accload = 1'b1; in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0; ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (ov !== 1'b1 || dout !== W'(1)) begin
                n_fail++; $display("FAIL freeze_%0d got v=%b d=%h want v=1 d=1", i, ov, dout);
            end
        end
        ce = 1'b1;
        tick();
        n_chk++; if (ov !== 1'b1 || dout !== W'(2)) begin n_fail++; $display("FAIL thaw got v=%b d=%h want v=1 d=2", ov, dout); end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_chk++; if (ov !== 1'b0 || dout !== W'(2)) begin n_fail++; $display("FAIL thaw_idle got v=%b d=%h want v=0 d=2", ov, dout); end
        tick();
        n_chk++; if (dout !== W'(3)) begin n_fail++; $display("FAIL thaw_acc got %h want 3", dout); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a = W'(1); accload = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_chk++; if (dout !== W'(3)) begin n_fail++; $display("FAIL mid_pre got %h want 3", dout); end
        reset = 1'b0;
        tick();
        n_chk++; if (ov !== 1'b0 || dout !== '0) begin n_fail++; $display("FAIL mid_reset got v=%b d=%h want 0/0", ov, dout); end
        reset = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_chk++; if (ov !== 1'b1 || dout !== W'(1)) begin n_fail++; $display("FAIL mid_after got v=%b d=%h want 1/1", ov, dout); end
    endtask

    task automatic test_mode3();
        do_reset();
        a = W'(9); in_valid = 1'b1;
        tick();
        mode = 2'd3; a = W'(5); b = W'(7); accload = 1'b1;
        tick();
        mode = 2'd0; a = '0; b = '0;
        tick();
        in_valid = 1'b0;
        n_chk++; if (ov !== 1'b1 || dout !== '0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL rsvd got v=%b d=%h o=%b want 1/0/0", ov, dout, ovf);
        end
        tick();
        n_chk++; if (dout !== W'(9)) begin n_fail++; $display("FAIL rsvd_acc got %h want 9", dout); end
    endtask

    task automatic test_random();
        res_t         eq[$];
        res_t         sq[$];
        res_t         e, es;
        smp_t         s;
        logic [W-1:0] macc, sacc;
        bit           ce_now;
        int           n_out;
        do_reset();
        macc = '0; sacc = '0; n_out = 0;
        for (int i = 0; i < 460; i++) begin
            if (i < 400) begin
                a = W'({$urandom(), $urandom()});
                b = W'({$urandom(), $urandom()});
                casi = (W+1)'({$urandom(), $urandom()});
                if ($urandom_range(0, 2) == 0) a = W'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) b = W'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) casi = (W+1)'($urandom_range(0, 15));
                asign = 1'($urandom); bsign = 1'($urandom);
                b_sub = 1'($urandom); c_sub = 1'($urandom);
                accload = 1'($urandom); mode = 2'($urandom);
                ce = ($urandom_range(0, 4) != 0);
                in_valid = ($urandom_range(0, 2) != 0);
            end else begin
                ce = 1'b1; in_valid = 1'b0;
            end
            s = '{a:a, b:b, casi:casi, asg:asign, bsg:bsign, bs:b_sub,
                  cs:c_sub, al:accload, md:mode};
            ce_now = ce;
            if (ce && in_valid) begin
                eq.push_back(model(s, 1'b0, macc));
                sq.push_back(model(s, 1'b1, sacc));
            end
            tick();
            if (ce_now && ov) begin
                n_chk++;
                if (eq.size() == 0 || sq.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra cycle %0d got out_valid=1 want none", i);
                end else begin
                    e = eq.pop_front();
                    es = sq.pop_front();
                    n_out++;
                    if (dout !== e.d || caso !== e.c || ovf !== e.o) begin
                        n_fail++;
                        $display("FAIL rnd_wrap #%0d got %h/%h/%b want %h/%h/%b",
                                 n_out, dout, caso, ovf, e.d, e.c, e.o);
                    end
                    n_chk++;
                    if (s_ov !== 1'b1 || s_dout !== es.d || s_caso !== es.c || s_ovf !== es.o) begin
                        n_fail++;
                        $display("FAIL rnd_sat #%0d got %b/%h/%h/%b want 1/%h/%h/%b",
                                 n_out, s_ov, s_dout, s_caso, s_ovf, es.d, es.c, es.o);
                    end
                end
            end
        end
        n_chk++;
        if (eq.size() != 0) begin
            n_fail++; $display("FAIL rnd_drain got %0d left want 0", eq.size());
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_cascade();
        test_saturate();
        test_ce_freeze();
        test_reset_mid();
        test_mode3();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_acc_chain.md
# alu_acc_chain

Parametrised, pipelined cascadable ALU/accumulator. It is the successor to the fixed-mode 54-bit DSP ALU primitive, with these additions:
- the operand width is a parameter;
- the mode is selected at run time;
- a valid-tagged pipeline;
- overflow detection with optional saturation.

It sits in DSP chains alongside the multiplier blocks. CASO of one instance feeds CASI of the next.

## Interface
Parameters:
- WIDTH, 54, operand/result width (≥ 8)
- IN_REG, 1, 1 = register all data/control inputs (one stage)
- OUT_REG, 1, 1 = register dout/caso/overflow/out_valid
- SATURATE, 0, 1 = clamp dout on overflow; 0 = wrap

Ports (clk/reset first):
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; priority over ce
- ce  in  1  clock enable for every register, including acc
- in_valid  in  1  sample present this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- casi  in  WIDTH+1  cascade in, signed
- asign, bsign  in  1 each  A/B are signed
- b_sub, c_sub  in  1 each  subtract B / subtract third operand
- mode  in  2  operation select, sampled with data
- accload  in  1  1 = use accumulator as C; 0 = C is 0
- out_valid  out  1  dout valid
- dout  out  WIDTH  result
- caso  out  WIDTH+1  full-precision pre-saturation sum
- overflow  out  1  result not representable in WIDTH

## Operation
Sign extension:
- A extends to WIDTH+2 bits using asign; B uses bsign; casi is sign-extended.
- Sum S is WIDTH+2 bits.
- Result is signed if asign|bsign, unsigned otherwise.

Modes (ACC = accload ? acc : 0; ±B from b_sub; ±third from c_sub):
- 0: S = A ± B ± ACC
- 1: S = ACC ± B ± casi (A ignored)
- 2: S = A ± B ± casi (accload ignored)
- 3: reserved. S = 0, overflow = 0, acc unchanged.

Overflow and saturation:
- overflow = S outside [-2^(W-1), 2^(W-1)-1] when signed; outside [0, 2^W-1] when unsigned.
- SATURATE=1: clamp dout to the nearest bound.
- SATURATE=0: dout = S[W-1:0].
- caso = S[WIDTH:0], never saturated.

Accumulator:
- acc is an internal WIDTH-bit register, always present.
- It loads the final dout value in modes 0–2 on every compute-stage valid with ce=1.
- The feedback path is single-cycle, so back-to-back accumulation sustains 1 sample/cycle.

Valid and hold behaviour:
- in_valid=0 at the compute stage: acc holds, out_valid=0, dout/caso/overflow hold their last values.
- ce=0: every register freezes, including valid bits. No sample is lost or duplicated.

Reset (reset=0 at an edge with ce ignored) clears:
- out_valid, dout, caso, overflow
- acc
- the pipeline valid bits

Reset mid-accumulation discards in-flight samples. The sample presented in the reset cycle is dropped.

## Timing
- Latency from in_valid to out_valid = IN_REG + OUT_REG cycles. Throughput is 1 sample/cycle.
- IN_REG=OUT_REG=0: dout/caso/overflow/out_valid are combinational from the inputs and acc; acc is still registered.
- With IN_REG=1, mode/accload/sign/sub controls are pipelined with their data and never mix across samples.
- Cascade: CASO→CASI is combinational between instances at the same stage. Chain timing is the integrator's concern.
- Simultaneous reset=0 and in_valid=1: reset wins.
- Simultaneous accload=1 and mode 2: accload is ignored and acc still updates.

## Structure
- Package alu_acc_pkg holds:
  - mode constants MODE_ADD_ACC=0, MODE_CASC_ACC=1, MODE_CASC=2, MODE_RSVD=3;
  - the saturation-bound function of (WIDTH, signed).
- Sub-module alu_acc_core: purely combinational. It covers operand extension, the three-input add/sub, the overflow test and the clamp.
- The top module holds the optional input stage, acc, the optional output stage and the valid pipeline.

## Test plan
- Mode 0, unsigned, b_sub=1, accload=0, a=0xde1ec7ab1e, b=0xcad -> dout=0xde1ec79e71, overflow=0, out_valid 2 cycles after in_valid.
- Mode 0, a=1, b=0, accload=1, 4 back-to-back valids after reset -> dout 1,2,3,4 on consecutive cycles; then 2 idle cycles -> dout stays 4, out_valid=0.
- Mode 2, a=0x100000000, b=0xf000, casi=0x1111 -> dout=caso=0x100010111. Chain two instances: the second in mode 1 with accload=0, b=2 -> S = 0 + 2 + casi = 0x100010113.
- Unsigned, a=2^54-1, b=1, mode 2, casi=0:
  - SATURATE=1 -> dout=2^54-1, overflow=1, caso=2^54;
  - SATURATE=0 -> dout=0, overflow=1.
- ce=0 for 3 cycles with 2 samples in flight -> outputs and acc frozen, then both samples emerge in order. reset=0 mid-accumulation (acc=3) -> next edge: dout=0, out_valid=0, acc=0. A following a=1 accumulation yields 1.
- Mode 3 with a=5, b=7, accload=1, acc=9 -> dout=0, overflow=0, acc remains 9.
